// File: rtl/alu_result_stage_pkg.sv
// Shared ALU opcode, branch-condition and flag-index definitions.
// Also holds the per-opcode flag-write and register-write decode.
package alu_result_stage_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_RSV7 = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd11;
  localparam logic [3:0] OP_IN = 4'd12;
  localparam logic [3:0] OP_OUT = 4'd13;
  localparam logic [3:0] OP_RSV14 = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  localparam logic [2:0] BR_BE = 3'd0;
  localparam logic [2:0] BR_BLT = 3'd1;
  localparam logic [2:0] BR_BLE = 3'd2;
  localparam logic [2:0] BR_BNE = 3'd3;
  localparam logic [2:0] BR_ALWAYS = 3'd4;

  localparam int unsigned FLAG_S = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Arithmetic/logic ops 0..11 update flags, except the reserved op 7.
  function automatic logic op_writes_flags(input logic [3:0] op);
    return (op <= OP_SRA) && (op != OP_RSV7);
  endfunction

  function automatic logic op_writes_reg(input logic [3:0] op);
    return !(op inside {OP_CMP, OP_RSV7, OP_OUT, OP_RSV14, OP_HLT});
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational conditional-branch decision from a {S,Z,C,V} flag set.
module branch_cond_eval
  import alu_result_stage_pkg::*;
(
  input  logic [3:0] eval_flags,
  input  logic [2:0] br_cond,
  output logic       taken
);

  logic s, z, v;
  assign s = eval_flags[FLAG_S];
  assign z = eval_flags[FLAG_Z];
  assign v = eval_flags[FLAG_V];

  always_comb begin
    taken = 1'b0;
    case (br_cond)
      BR_BE:     taken = z;
      BR_BLT:    taken = s ^ v;
      BR_BLE:    taken = z | (s ^ v);
      BR_BNE:    taken = ~z;
      BR_ALWAYS: taken = 1'b1;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: flag register, 2-entry writeback queue, branch
// evaluation with same-cycle flag bypass, and HLT freeze.
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [DATA_W-1:0] in_res,
  input  logic              in_s,
  input  logic              in_z,
  input  logic              in_c,
  input  logic              in_v,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_res,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_we,
  output logic              out_halt,
  output logic [3:0]        flags,
  input  logic              br_valid,
  input  logic [2:0]        br_cond,
  output logic              br_taken,
  output logic              br_done,
  output logic              halted
);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] res_q [2];
  logic [RD_W-1:0]   rd_q [2];
  logic [1:0]        we_q, halt_q;
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q;
  logic [3:0]        flags_q;
  logic              br_taken_q, br_done_q;

  logic       accept, pop, flag_wr, cond_taken;
  logic [3:0] in_flags, eval_flags;

  // in_ready depends only on registers so upstream sees no comb path.
  assign in_ready  = (count_q != 2'd2) && (state_q == StRun);
  assign accept    = in_valid & in_ready;
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign in_flags  = {in_s, in_z, in_c, in_v};
  assign flag_wr   = accept & op_writes_flags(in_op);
  assign eval_flags = flag_wr ? in_flags : flags_q;

  assign out_res  = res_q[rd_ptr_q];
  assign out_rd   = rd_q[rd_ptr_q];
  assign out_we   = we_q[rd_ptr_q];
  assign out_halt = halt_q[rd_ptr_q];
  assign flags    = flags_q;
  assign br_taken = br_taken_q;
  assign br_done  = br_done_q;
  assign halted   = (state_q == StHalt);

  branch_cond_eval u_branch_cond_eval (
    .eval_flags (eval_flags),
    .br_cond    (br_cond),
    .taken      (cond_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        res_q[i] <= '0;
        rd_q[i]  <= '0;
      end
      we_q     <= '0;
      halt_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (accept) begin
        res_q[wr_ptr_q]  <= in_res;
        rd_q[wr_ptr_q]   <= in_rd;
        we_q[wr_ptr_q]   <= in_we & op_writes_reg(in_op);
        halt_q[wr_ptr_q] <= (in_op == OP_HLT);
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (accept && !pop) begin
        count_q <= count_q + 2'd1;
      end else if (!accept && pop) begin
        count_q <= count_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q    <= 4'd0;
      br_taken_q <= 1'b0;
      br_done_q  <= 1'b0;
    end else begin
      if (flag_wr) begin
        flags_q <= in_flags;
      end
      br_done_q  <= br_valid;
      br_taken_q <= br_valid && (state_q == StRun) && cond_taken;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      case (state_q)
        StRun:   if (accept && (in_op == OP_HLT)) state_q <= StHalt;
        StHalt:  state_q <= StHalt;
        default: state_q <= StRun;
      endcase
    end
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Stage directly downstream of the 16-bit ALU: captures ALU result and S/Z/C/V flags, maintains the architectural flag register, and buffers results toward register writeback in a 2-entry valid/ready queue.
- Evaluates conditional-branch conditions against the committed flags, with same-cycle bypass.
- Tracks processor halt on HLT.

Parameters:
- DATA_W, 16, result width (matches ALU res)
- RD_W, 3, destination register index width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ALU result presented
- in_ready  out  1  stage can accept
- in_op  in  4  ALU opcode of the instruction (same encoding as ALU op)
- in_res  in  DATA_W  ALU result
- in_s, in_z, in_c, in_v  in  1 each  ALU flags
- in_rd  in  RD_W  destination register
- in_we  in  1  decoder register-write intent
- out_valid  out  1  head entry valid
- out_ready  in  1  writeback accepts head
- out_res  out  DATA_W  head result
- out_rd  out  RD_W  head destination
- out_we  out  1  head writes register file
- out_halt  out  1  head entry is HLT
- flags  out  4  committed {S,Z,C,V}
- br_valid  in  1  branch evaluation request (single-cycle strobe)
- br_cond  in  3  0 BE, 1 BLT, 2 BLE, 3 BNE, 4 always, 5-7 never
- br_taken  out  1  registered branch decision
- br_done  out  1  one-cycle pulse, decision valid
- halted  out  1  HLT accepted; stage frozen

Behaviour:
- Reset (async, rst_n=0): queue empty (count=0, pointers 0), flags=0, br_taken=0, br_done=0, halted=0, all out_* data = 0. Reset mid-operation discards queued entries and pending branch results.
- Accept = in_valid & in_ready. in_ready = (count<2) & ~halted, purely from registers; no combinational path from out_ready or in_valid.
- Queue: 2 entries, 1-bit read/write pointers wrapping 1->0. Push on accept, pop on out_valid & out_ready. Push and pop in the same cycle: count unchanged. Full (count=2) forces in_ready=0. Empty forces out_valid=0. out_* driven directly from the head entry register; zero added latency beyond the write (accepted entry visible on out_* next cycle).
- Stored we = in_we & (in_op not in {5 CMP, 7, 13 OUT, 14, 15 HLT}). Stored halt = (in_op==15).
- Flag write: on accept with in_op in {0..6, 8..11}, flags <= {in_s,in_z,in_c,in_v} at that edge. Ops 7 and 12..15 hold flags. Values are captured as supplied, with no recomputation.
- Branch evaluation uses eval_flags:
  - equal to incoming flags when a flag-writing accept occurs in the same cycle, otherwise the flags register.
  - BE: Z. BLT: S^V. BLE: Z|(S^V). BNE: ~Z. Code 4: 1. Codes 5-7: 0.
  - br_valid at edge t gives br_done=1 and br_taken=cond during cycle t+1.
  - Without br_valid, br_done=0 and br_taken=0.
  - Back-to-back strobes yield back-to-back results.
- Halt FSM, states RUN and HALT:
  - RUN->HALT on accept of op 15; halted=1 from the next cycle.
  - The HLT entry is still enqueued (we=0, halt=1) and drains normally.
  - In HALT: in_ready=0, flags frozen, queue continues draining, br_valid still yields br_done with br_taken=0.
  - HALT exits only via reset.
- in_valid while in_ready=0: no state change; upstream holds its data (no drop).

Decomposition:
- Shared package (e.g. core_pkg): opcode constants (OP_ADD=0 ... OP_SRA=11, OP_IN=12, OP_OUT=13, OP_HLT=15), branch condition codes, and flag bit indices (S=3, Z=2, C=1, V=0). The ALU uses the same constants.
- Sub-module branch_cond_eval: combinational; inputs eval_flags and br_cond, output taken. Shared with any later branch predictor/check.
- Queue and halt FSM stay inline.

Test Plan:
- ADD (op 0), res=0x0000, Z=1, C=1, in_we=1, rd=2, out_ready=1 -> next cycle out_valid=1, out_res=0x0000, out_rd=2, out_we=1; flags=4'b0110.
- CMP (op 5), flags S=1,V=0, in_we=1, with br_valid and br_cond=1 in the same cycle -> out_we=0; next cycle br_done=1, br_taken=1 (bypass); flags=4'b1000.
- out_ready=0, push 3 results 0x0011, 0x0022, 0x0033 -> in_ready=0 after the 2nd; 3rd held. Raise out_ready -> outputs 0x0011, 0x0022, 0x0033 in order; no loss or duplication.
- OUT (op 13) with in_we=1 after flags=4'b0100 -> out_we=0, flags unchanged. BNE request -> br_taken=0.
- HLT (op 15) queued behind one pending entry -> halted=1 next cycle, in_ready stays 0. Both entries drain, the second with out_halt=1. br_valid in HALT -> br_done=1, br_taken=0.
- Assert rst_n=0 asynchronously with 2 entries queued and br_valid pending -> out_valid, flags, br_done, halted all 0 immediately; in_ready=1 after release.
